pipelined_segment_adder: RTL and testbench
==========================================

Name: pipelined_segment_adder

Overview:
- Parametrised successor to the team's single-bit adder.
- Adds or subtracts two WIDTH-bit operands through a carry-pipelined datapath of WIDTH/SEG stages. Each stage resolves one SEG-bit slice and passes its carry to the next stage.
- Used in later lab datapaths where a wide combinational carry chain would not meet timing.
- Valid/ready handshake on both sides, with full-pipeline stall under backpressure.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of SEG.
- SEG, 4, bits resolved per pipeline stage; 1 <= SEG <= WIDTH.
- (derived) NSEG = WIDTH/SEG, number of stages; equals the latency.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input operands valid
- in_ready  out  1  block can accept input this cycle
- A  in  WIDTH  operand A, unsigned or two's complement
- B  in  WIDTH  operand B
- sub  in  1  0: A+B+cin; 1: A-B (B inverted, carry-in forced to 1, cin ignored)
- cin  in  1  carry-in, add mode only
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- Output  out  WIDTH+1  {carry_out, sum[WIDTH-1:0]}
- ovf  out  1  signed overflow of the WIDTH-bit result

Behaviour:
- Interface fixed: one clock domain (clk); reset rst is synchronous and active-high.
- Reset: all stage valid bits cleared; out_valid=0, Output=0, ovf=0. in_ready=1 in the cycle after reset deasserts. Reset mid-operation discards all in-flight data with no partial output.
- Global advance: adv = ~out_valid | out_ready; in_ready = adv (combinational, no dependency on in_valid).
- When adv=1, every stage register loads from its predecessor and stage 1 loads {in_valid, operands}. A bubble (in_valid=0) propagates as valid=0.
- When adv=0, all stage registers hold, including Output and ovf.
- Input transfer occurs when in_valid & in_ready. Output transfer occurs when out_valid & out_ready.
- Stage 1 captures:
  - A
  - Beff = sub ? ~B : B
  - c0 = sub ? 1 : cin
  - the top bit of A and the top bit of Beff, for overflow.
- Stage k (1..NSEG) computes slice k-1, bits [k*SEG-1:(k-1)*SEG], as slice_A + slice_Beff + carry_in (SEG+1 bits).
  - Carry_in is c0 for k=1, otherwise the registered carry from stage k-1.
  - Each stage forwards the sum slices computed so far plus the unconsumed operand slices (skew pipeline).
- Latency: a result accepted at edge t is presented with out_valid=1 after edge t+NSEG-1 (that is, NSEG register stages). Throughput is 1 result per cycle when out_ready=1.
- Output[WIDTH] = carry out of the top slice. In sub mode this equals 1 when A >= B (unsigned), i.e. no borrow.
- ovf = (A_msb == Beff_msb) & (sum_msb != A_msb), registered alongside Output.
- Wrap-around: the sum is modulo 2^WIDTH in Output[WIDTH-1:0]; Output[WIDTH] is never dropped.
- Simultaneous events:
  - out_ready=0 with in_valid=1 while out_valid=1: input not taken (in_ready=0), no data lost.
  - out_valid=0 with a pipeline full of bubbles: adv=1 even if out_ready=0.
- Result order equals input order; no reordering, no duplication.
- NSEG=1 (SEG=WIDTH) degenerates to a single registered adder with latency 1.

Test Plan:
- Add, WIDTH=16/SEG=4: A=16'h1234, B=16'h0FFF, cin=0, sub=0, out_ready=1 -> after 4 edges Output=17'h02233, ovf=0, out_valid high exactly 1 cycle.
- Carry ripple across all slices: A=16'hFFFF, B=16'h0000, cin=1 -> Output=17'h10000, ovf=0; then A=16'h7FFF, B=16'h0001 -> Output=17'h08000, ovf=1.
- Subtract: A=16'h0005, B=16'h0007, sub=1, cin=1 (ignored) -> Output=17'h0FFFE (carry 0 = borrow), ovf=0; A=16'h8000, B=16'h0001, sub=1 -> Output=17'h17FFF, ovf=1.
- Back-to-back stream with backpressure: 8 consecutive inputs, hold out_ready=0 for cycles 6-9 after first input -> in_ready=0 during the stall, Output held stable, all 8 results emerge in order with no loss or duplicate.
- Reset mid-operation: 3 transactions in flight, assert rst for 1 cycle -> out_valid=0 and Output=0 next cycle, no stale result ever appears, a new input afterward returns after exactly 4 edges.
- Parameter sweep: SEG=16 (latency 1) and SEG=1 (latency 16) with random A/B/sub against a reference model -> all results and ovf match.

Source files
------------

// File: rtl/pipelined_segment_adder.sv
// Carry-pipelined adder/subtractor. Each stage resolves one SEG-bit slice
// and hands its carry to the next stage. The whole pipeline stalls together
// under backpressure.
module pipelined_segment_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SEG   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   Output,
    output logic             ovf
);

    localparam int unsigned NSEG = WIDTH / SEG;

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    // Per-stage sources (what the stage consumes) and registered state.
    // Operands are shifted down by SEG each stage, so the next slice is
    // always in the low bits. Sum slices enter at the top and shift down,
    // so slice 0 lands at bit 0 after the last stage.
    logic             v_src  [NSEG];
    logic             c_src  [NSEG];
    logic             am_src [NSEG];
    logic             bm_src [NSEG];
    logic [WIDTH-1:0] a_src  [NSEG];
    logic [WIDTH-1:0] b_src  [NSEG];
    logic [WIDTH-1:0] s_src  [NSEG];
    logic [SEG:0]     slice  [NSEG];
    logic [WIDTH-1:0] s_top  [NSEG];

    logic             v_q    [NSEG];
    logic             c_q    [NSEG];
    logic             am_q   [NSEG];
    logic             bm_q   [NSEG];
    logic [WIDTH-1:0] a_q    [NSEG];
    logic [WIDTH-1:0] b_q    [NSEG];
    logic [WIDTH-1:0] s_q    [NSEG];

    assign b_eff    = sub ? ~B : B;
    assign c0       = sub | cin;
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < NSEG; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign v_src[k]  = in_valid;
            assign c_src[k]  = c0;
            assign am_src[k] = A[WIDTH-1];
            assign bm_src[k] = b_eff[WIDTH-1];
            assign a_src[k]  = A;
            assign b_src[k]  = b_eff;
            assign s_src[k]  = '0;
        end else begin : g_next
            assign v_src[k]  = v_q[k-1];
            assign c_src[k]  = c_q[k-1];
            assign am_src[k] = am_q[k-1];
            assign bm_src[k] = bm_q[k-1];
            assign a_src[k]  = a_q[k-1];
            assign b_src[k]  = b_q[k-1];
            assign s_src[k]  = s_q[k-1];
        end

        assign slice[k] = {1'b0, a_src[k][SEG-1:0]} + {1'b0, b_src[k][SEG-1:0]}
                        + {{SEG{1'b0}}, c_src[k]};
        assign s_top[k] = WIDTH'(slice[k][SEG-1:0]) << (WIDTH - SEG);

        // Stage register: loads from its predecessor on advance, holds on stall.
        always_ff @(posedge clk) begin
            if (rst) begin
                v_q[k]  <= 1'b0;
                c_q[k]  <= 1'b0;
                am_q[k] <= 1'b0;
                bm_q[k] <= 1'b0;
                a_q[k]  <= '0;
                b_q[k]  <= '0;
                s_q[k]  <= '0;
            end else if (adv) begin
                v_q[k]  <= v_src[k];
                c_q[k]  <= slice[k][SEG];
                am_q[k] <= am_src[k];
                bm_q[k] <= bm_src[k];
                a_q[k]  <= a_src[k] >> SEG;
                b_q[k]  <= b_src[k] >> SEG;
                s_q[k]  <= (s_src[k] >> SEG) | s_top[k];
            end
        end
    end

    // Operands are fully consumed by the last stage.
    logic unused_ops;
    assign unused_ops = ^{a_q[NSEG-1], b_q[NSEG-1]};

    assign out_valid = v_q[NSEG-1];
    assign Output    = {c_q[NSEG-1], s_q[NSEG-1]};
    assign ovf       = (am_q[NSEG-1] == bm_q[NSEG-1])
                     & (s_q[NSEG-1][WIDTH-1] != am_q[NSEG-1]);

endmodule

// File: tb/tb_pipelined_segment_adder.sv
// Bench for pipelined_segment_adder: three instances (SEG=4, 16, 1) share
// stimulus; each has a scoreboard fed on input transfer, checked on output.
module tb_pipelined_segment_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        sub = 1'b0;
    logic        cin = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] a_in = '0;
    logic [15:0] b_in = '0;

    logic        ir_m, ov_m, ovf_m;
    logic [16:0] out_m;
    logic        ir_w, ov_w, ovf_w;
    logic [16:0] out_w;
    logic        ir_n, ov_n, ovf_n;
    logic [16:0] out_n;

    int n_tests = 0;
    int n_fail  = 0;

    logic [17:0] q_m[$];
    logic [17:0] q_w[$];
    logic [17:0] q_n[$];

    always #5 clk = ~clk;

    pipelined_segment_adder #(.WIDTH(16), .SEG(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_m), .A(a_in), .B(b_in),
        .sub(sub), .cin(cin), .out_valid(ov_m), .out_ready(out_ready), .Output(out_m),
        .ovf(ovf_m)
    );

    pipelined_segment_adder #(.WIDTH(16), .SEG(16)) dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_w), .A(a_in), .B(b_in),
        .sub(sub), .cin(cin), .out_valid(ov_w), .out_ready(out_ready), .Output(out_w),
        .ovf(ovf_w)
    );

    pipelined_segment_adder #(.WIDTH(16), .SEG(1)) dut_n (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_n), .A(a_in), .B(b_in),
        .sub(sub), .cin(cin), .out_valid(ov_n), .out_ready(out_ready), .Output(out_n),
        .ovf(ovf_n)
    );

    // Reference: {ovf, carry, sum} from a full-width add.
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic s, input logic c);
        logic [15:0] be;
        logic [16:0] r;
        logic        o;
        be = s ? ~b : b;
        r  = {1'b0, a} + {1'b0, be} + {16'b0, (s | c)};
        o  = (a[15] == be[15]) && (r[15] != a[15]);
        return {o, r};
    endfunction

    // Scoreboard: expectations pushed on input transfer, compared on output transfer.
    always @(negedge clk) begin
        logic [17:0] e;
        if (rst) begin
            q_m.delete();
            q_w.delete();
            q_n.delete();
        end else begin
            if (ov_m && out_ready) begin
                n_tests++;
                if (q_m.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_seg4: unexpected output %h, expected none", out_m);
                end else begin
                    e = q_m.pop_front();
                    if ({ovf_m, out_m} !== e) begin
                        n_fail++;
                        $display("FAIL sb_seg4: got %h, expected %h", {ovf_m, out_m}, e);
                    end
                end
            end
            if (ov_w && out_ready) begin
                n_tests++;
                if (q_w.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_seg16: unexpected output %h, expected none", out_w);
                end else begin
                    e = q_w.pop_front();
                    if ({ovf_w, out_w} !== e) begin
                        n_fail++;
                        $display("FAIL sb_seg16: got %h, expected %h", {ovf_w, out_w}, e);
                    end
                end
            end
            if (ov_n && out_ready) begin
                n_tests++;
                if (q_n.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_seg1: unexpected output %h, expected none", out_n);
                end else begin
                    e = q_n.pop_front();
                    if ({ovf_n, out_n} !== e) begin
                        n_fail++;
                        $display("FAIL sb_seg1: got %h, expected %h", {ovf_n, out_n}, e);
                    end
                end
            end
            if (in_valid && ir_m) q_m.push_back(model(a_in, b_in, sub, cin));
            if (in_valid && ir_w) q_w.push_back(model(a_in, b_in, sub, cin));
            if (in_valid && ir_n) q_n.push_back(model(a_in, b_in, sub, cin));
        end
    end

    // Drive one transaction into an idle pipeline and observe the SEG=4 instance.
    task automatic run_single(input logic [15:0] a, input logic [15:0] b, input logic s,
                              input logic c, output logic [16:0] o, output logic ov,
                              output int lat, output logic single);
        a_in = a; b_in = b; sub = s; cin = c; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (ov_m !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        o  = out_m;
        ov = ovf_m;
        @(posedge clk); #1;
        single = (ov_m === 1'b0);
    endtask

    task automatic test_reset();
        n_tests++;
        if (ov_m !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, expected 0", ov_m); end
        n_tests++;
        if (out_m !== 17'h0) begin n_fail++; $display("FAIL reset_output: got %h, expected 00000", out_m); end
        n_tests++;
        if (ovf_m !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b, expected 0", ovf_m); end
        n_tests++;
        if (ir_m !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b, expected 1", ir_m); end
        n_tests++;
        if ({ov_w, ov_n} !== 2'b00) begin
            n_fail++; $display("FAIL reset_others_valid: got %b, expected 00", {ov_w, ov_n});
        end
    endtask

    task automatic test_add();
        logic [16:0] o; logic ov; int lat; logic single;
        run_single(16'h1234, 16'h0FFF, 1'b0, 1'b0, o, ov, lat, single);
        n_tests++;
        if (o !== 17'h02233) begin n_fail++; $display("FAIL add_output: got %h, expected 02233", o); end
        n_tests++;
        if (ov !== 1'b0) begin n_fail++; $display("FAIL add_ovf: got %b, expected 0", ov); end
        n_tests++;
        if (lat != 4) begin n_fail++; $display("FAIL add_latency: got %0d, expected 4", lat); end
        n_tests++;
        if (single !== 1'b1) begin n_fail++; $display("FAIL add_single_pulse: got %b, expected 1", single); end
    endtask

    task automatic test_carry();
        logic [16:0] o; logic ov; int lat; logic single;
        run_single(16'hFFFF, 16'h0000, 1'b0, 1'b1, o, ov, lat, single);
        n_tests++;
        if ({ov, o} !== 18'h10000) begin
            n_fail++; $display("FAIL carry_ripple: got %h, expected 10000 ovf 0", {ov, o});
        end
        run_single(16'h7FFF, 16'h0001, 1'b0, 1'b0, o, ov, lat, single);
        n_tests++;
        if (o !== 17'h08000) begin n_fail++; $display("FAIL carry_signed: got %h, expected 08000", o); end
        n_tests++;
        if (ov !== 1'b1) begin n_fail++; $display("FAIL carry_signed_ovf: got %b, expected 1", ov); end
    endtask

    task automatic test_sub();
        logic [16:0] o; logic ov; int lat; logic single;
        run_single(16'h0005, 16'h0007, 1'b1, 1'b1, o, ov, lat, single);
        n_tests++;
        if (o !== 17'h0FFFE) begin n_fail++; $display("FAIL sub_borrow: got %h, expected 0FFFE", o); end
        n_tests++;
        if (ov !== 1'b0) begin n_fail++; $display("FAIL sub_borrow_ovf: got %b, expected 0", ov); end
        run_single(16'h8000, 16'h0001, 1'b1, 1'b0, o, ov, lat, single);
        n_tests++;
        if (o !== 17'h17FFF) begin n_fail++; $display("FAIL sub_signed: got %h, expected 17FFF", o); end
        n_tests++;
        if (ov !== 1'b1) begin n_fail++; $display("FAIL sub_signed_ovf: got %b, expected 1", ov); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] av [8];
        logic [15:0] bv [8];
        logic [16:0] held;
        logic        have_hold;
        int sent, got, cyc;
        for (int i = 0; i < 8; i++) begin
            av[i] = 16'($urandom);
            bv[i] = 16'($urandom);
        end
        sent = 0; got = 0; cyc = 0; have_hold = 1'b0; held = '0;
        while ((sent < 8 || got < 8) && cyc < 100) begin
            out_ready = !(cyc >= 6 && cyc <= 9);
            if (sent < 8) begin
                in_valid = 1'b1; a_in = av[sent]; b_in = bv[sent];
                sub = sent[0]; cin = sent[1];
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (!out_ready && ov_m) begin
                n_tests++;
                if (ir_m !== 1'b0) begin
                    n_fail++; $display("FAIL stall_in_ready: got %b, expected 0 (cycle %0d)", ir_m, cyc);
                end
                if (have_hold) begin
                    n_tests++;
                    if (out_m !== held) begin
                        n_fail++; $display("FAIL stall_hold: got %h, expected %h", out_m, held);
                    end
                end
                held = out_m;
                have_hold = 1'b1;
            end
            if (in_valid && ir_m) sent++;
            if (ov_m && out_ready) got++;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_tests++;
        if (got != 8) begin n_fail++; $display("FAIL b2b_count: got %0d results, expected 8", got); end
        n_tests++;
        if (!have_hold) begin n_fail++; $display("FAIL b2b_stall_seen: got 0 stall cycles, expected 4"); end
        n_tests++;
        if (q_m.size() != 0) begin
            n_fail++; $display("FAIL b2b_drained: got %0d pending, expected 0", q_m.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [16:0] o; logic ov; int lat; logic single;
        logic stale;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a_in = 16'($urandom); b_in = 16'($urandom); sub = 1'b0; cin = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_tests++;
        if (ov_m !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b, expected 0", ov_m); end
        n_tests++;
        if (out_m !== 17'h0) begin n_fail++; $display("FAIL midrst_output: got %h, expected 00000", out_m); end
        n_tests++;
        if (ovf_m !== 1'b0) begin n_fail++; $display("FAIL midrst_ovf: got %b, expected 0", ovf_m); end
        stale = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (ov_m !== 1'b0 || ov_w !== 1'b0 || ov_n !== 1'b0) stale = 1'b1;
            @(posedge clk); #1;
        end
        n_tests++;
        if (stale !== 1'b0) begin n_fail++; $display("FAIL midrst_stale: got 1, expected 0"); end
        run_single(16'h00FF, 16'h0101, 1'b0, 1'b1, o, ov, lat, single);
        n_tests++;
        if (lat != 4) begin n_fail++; $display("FAIL midrst_latency: got %0d, expected 4", lat); end
        n_tests++;
        if (o !== 17'h00201) begin n_fail++; $display("FAIL midrst_result: got %h, expected 00201", o); end
    endtask

    task automatic test_sweep();
        int lat_w, lat_n;
        logic [15:0] corner [4];
        corner[0] = 16'h0000; corner[1] = 16'hFFFF; corner[2] = 16'h8000; corner[3] = 16'h7FFF;
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        in_valid = 1'b1; a_in = 16'h4321; b_in = 16'h1111; sub = 1'b1; cin = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat_w = 0; lat_n = 0;
        for (int e = 1; e <= 24; e++) begin
            if (ov_w === 1'b1 && lat_w == 0) lat_w = e;
            if (ov_n === 1'b1 && lat_n == 0) lat_n = e;
            @(posedge clk); #1;
        end
        n_tests++;
        if (lat_w != 1) begin n_fail++; $display("FAIL sweep_lat_seg16: got %0d, expected 1", lat_w); end
        n_tests++;
        if (lat_n != 16) begin n_fail++; $display("FAIL sweep_lat_seg1: got %0d, expected 16", lat_n); end
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(0, 4) != 0);
            a_in      = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 16'($urandom);
            b_in      = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 16'($urandom);
            sub       = 1'($urandom_range(0, 1));
            cin       = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (24) @(posedge clk);
        #1;
        n_tests++;
        if (q_m.size() != 0) begin n_fail++; $display("FAIL sweep_drain_seg4: got %0d, expected 0", q_m.size()); end
        n_tests++;
        if (q_w.size() != 0) begin n_fail++; $display("FAIL sweep_drain_seg16: got %0d, expected 0", q_w.size()); end
        n_tests++;
        if (q_n.size() != 0) begin n_fail++; $display("FAIL sweep_drain_seg1: got %0d, expected 0", q_n.size()); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_add();
        test_carry();
        test_sub();
        test_back_to_back();
        test_reset_mid();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
